estagio_operandos: RTL
======================

ESTAGIO_OPERANDOS -- requirements
Module: estagio_operandos

Interface
REQ-001 SHALL have: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; clears all state.
REQ-003 SHALL have: in_valid  in  1  decoded instruction present; in_ready  out  1  stage accepts this cycle.
REQ-004 SHALL have: rs, rt, rd  in  5 each  source/destination register indices.
REQ-005 SHALL have: ULAop_in  in  4; FuncCode_in  in  6  passed to the ALU stage unchanged.
REQ-006 SHALL have: imm  in  32  immediate; usa_imm  in  1  B takes imm instead of reg[rt].
REQ-007 SHALL have: wb_en  in  1; wb_addr  in  5; wb_data  in  32  writeback port.
REQ-008 SHALL have: flush  in  1  discard held entry.
REQ-009 SHALL have: out_valid  out  1; out_ready  in  1  ALU stage consumes.
REQ-010 SHALL have: A, B  out  32; ULAop  out  4; FuncCode  out  6; rd_out  out  5; all registered.

Function
REQ-011 SHALL contain 32x32-bit register file; reg[0] always reads 0; writes to index 0 ignored.
REQ-012 SHALL write reg[wb_addr]=wb_data on clock edge when wb_en=1, independent of stall, flush, or handshake state.
REQ-013 SHALL read operands combinationally with bypass: if wb_en=1, wb_addr=index, index!=0, operand = wb_data, else file contents.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational; single-entry pipeline register, no skid buffer).
REQ-015 SHALL capture on edge when in_valid && in_ready: A=op(rs), B=usa_imm ? imm : op(rt), ULAop, FuncCode, rd_out, internal rs/rt/usa_imm copies; out_valid=1 next cycle. Latency 1 cycle.
REQ-016 SHALL clear out_valid when out_valid && out_ready and no capture in same cycle; back-to-back capture+consume keeps out_valid=1 with new data.
REQ-017 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, while holding (out_valid=1, out_ready=0), refresh A with wb_data if wb_en=1 and wb_addr equals held rs (nonzero); likewise B for held rt when held usa_imm=0.
REQ-019 SHALL, on flush=1, set out_valid=0 next edge; flush overrides capture in same cycle; in_ready unaffected by flush.
REQ-020 SHALL leave data outputs at last value when out_valid=0; consumers rely only on out_valid.
REQ-021 SHALL treat all operands as raw 32-bit words; no sign extension or arithmetic performed here.

Reset
REQ-022 SHALL, on reset low, asynchronously clear all 32 registers, out_valid, A, B, ULAop, FuncCode, rd_out to 0.
REQ-023 SHALL, reset asserted mid-hold, drop held entry; after release in_ready=1 on first cycle.
REQ-024 SHALL ignore wb_en while reset is low.

Verification
REQ-025 Write reg[5]=0x00000007, reg[6]=0x00000003; issue rs=5, rt=6, usa_imm=0, out_ready=1 -> next cycle out_valid=1, A=7, B=3.
REQ-026 Same cycle wb_en=1, wb_addr=5, wb_data=0xDEADBEEF with issue rs=5 -> A=0xDEADBEEF (bypass); wb_addr=0 -> A=0 and reg[0] stays 0.
REQ-027 out_ready=0 for 3 cycles after capture -> in_ready=0, outputs stable; wb to held rs=5 with 0x11 during hold -> A becomes 0x11 next cycle.
REQ-028 usa_imm=1, imm=0x0000FFFF, rt=6 -> B=0x0000FFFF regardless of reg[6]; held-B not refreshed by wb to rt.
REQ-029 flush=1 with in_valid=1, in_ready=1 -> out_valid=0 next cycle, entry not captured.
REQ-030 reset pulsed low while out_valid=1 -> out_valid=0, A=B=0 immediately; reading reg[5] after release gives 0.

Source files
------------

// File: rtl/estagio_operandos.sv
// estagio_operandos: operand fetch stage with register file, writeback bypass and single-entry output register
module estagio_operandos (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [3:0]  ULAop_in,
    input  logic [5:0]  FuncCode_in,
    input  logic [31:0] imm,
    input  logic        usa_imm,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ULAop,
    output logic [5:0]  FuncCode,
    output logic [4:0]  rd_out
);
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        valid_q, valid_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  ula_q, ula_d;
    logic [5:0]  func_q, func_d;
    logic [4:0]  rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic        imm_q, imm_d;
    logic [31:0] op_a, op_b;
    logic        capture, hold, wb_hit_a, wb_hit_b;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign A         = a_q;
    assign B         = b_q;
    assign ULAop     = ula_q;
    assign FuncCode  = func_q;
    assign rd_out    = rd_q;

    // Register file update; index 0 is never written so it always reads 0
    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
    end

    // Operand read with writeback bypass, capture/hold/refresh of the output entry
    always_comb begin
        op_a     = (rs == 5'd0) ? 32'd0 : (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
        op_b     = (rt == 5'd0) ? 32'd0 : (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
        capture  = in_valid && in_ready && !flush;
        hold     = valid_q && !out_ready;
        wb_hit_a = hold && wb_en && wb_addr != 5'd0 && wb_addr == rs_q;
        wb_hit_b = hold && wb_en && wb_addr != 5'd0 && wb_addr == rt_q && !imm_q;
        valid_d  = flush ? 1'b0 : capture ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
        a_d      = capture ? op_a : wb_hit_a ? wb_data : a_q;
        b_d      = capture ? (usa_imm ? imm : op_b) : wb_hit_b ? wb_data : b_q;
        ula_d    = capture ? ULAop_in : ula_q;
        func_d   = capture ? FuncCode_in : func_q;
        rd_d     = capture ? rd : rd_q;
        rs_d     = capture ? rs : rs_q;
        rt_d     = capture ? rt : rt_q;
        imm_d    = capture ? usa_imm : imm_q;
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Pipeline output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            ula_q   <= 4'd0;
            func_q  <= 6'd0;
            rd_q    <= 5'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            imm_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ula_q   <= ula_d;
            func_q  <= func_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
        end
    end
endmodule
